// File: rtl/spm_seq.sv
// Sequencer around a serial-parallel multiplier: latches a signed operand pair,
// streams B sign-extended LSB-first into the multiplier, and deserializes the product.
module spm_seq #(
   parameter int SIZE  = 32,
   parameter int P_DLY = 1
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [SIZE-1:0]   in_a,
   input  logic [SIZE-1:0]   in_b,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [2*SIZE-1:0] out_prod,
   output logic              mul_rst,
   output logic [SIZE-1:0]   mul_x,
   output logic              mul_y,
   input  logic              mul_p
);

   localparam int NBITS = 2 * SIZE;
   localparam int LAST  = NBITS + P_DLY - 1;
   localparam int CW    = $clog2(NBITS + P_DLY + 1);

   typedef enum logic [1:0] {IDLE, CLR, SHIFT, DONE} state_t;

   state_t             state_reg, state_next;
   logic [CW-1:0]      cnt_reg;
   logic [SIZE-1:0]    y_reg;
   logic [SIZE-1:0]    x_reg;
   logic [NBITS-1:0]   acc_reg;
   logic [NBITS-1:0]   prod_reg;
   logic               out_valid_reg;
   logic               mul_y_reg;
   logic               last;

   assign last      = (cnt_reg == CW'(LAST));
   assign in_ready  = (state_reg == IDLE) && !rst;
   assign mul_rst   = rst || (state_reg == CLR);
   assign out_valid = out_valid_reg;
   assign out_prod  = prod_reg;
   assign mul_x     = x_reg;
   assign mul_y     = mul_y_reg;

   always_comb begin
      state_next = state_reg;
      case (state_reg)
         IDLE:    if (in_valid) state_next = CLR;
         CLR:     state_next = SHIFT;
         SHIFT:   if (last) state_next = DONE;
         DONE:    if (out_ready) state_next = IDLE;
         default: state_next = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_reg     <= IDLE;
         cnt_reg       <= '0;
         y_reg         <= '0;
         x_reg         <= '0;
         acc_reg       <= '0;
         prod_reg      <= '0;
         out_valid_reg <= 1'b0;
         mul_y_reg     <= 1'b0;
      end else begin
         state_reg <= state_next;
         case (state_reg)
            IDLE: begin
               mul_y_reg <= 1'b0;
               if (in_valid) begin
                  x_reg   <= in_a;
                  y_reg   <= in_b;
                  acc_reg <= '0;
               end
            end
            CLR: begin
               // Preload bit 0 so it is on mul_y during the first SHIFT cycle.
               cnt_reg   <= '0;
               mul_y_reg <= y_reg[0];
               y_reg     <= {y_reg[SIZE-1], y_reg[SIZE-1:1]};
            end
            SHIFT: begin
               cnt_reg   <= cnt_reg + CW'(1);
               mul_y_reg <= last ? 1'b0 : y_reg[0];
               y_reg     <= {y_reg[SIZE-1], y_reg[SIZE-1:1]};
               // mul_p lags mul_y by P_DLY cycles, so the first P_DLY cycles carry no product bit.
               if (cnt_reg >= CW'(P_DLY))
                  acc_reg <= {mul_p, acc_reg[NBITS-1:1]};
               if (last) begin
                  prod_reg      <= {mul_p, acc_reg[NBITS-1:1]};
                  out_valid_reg <= 1'b1;
               end
            end
            DONE: begin
               if (out_ready) out_valid_reg <= 1'b0;
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_spm_seq.sv
// Bench for spm_seq: arithmetic model of the serial multiplier plus directed,
// random, backpressure, reset and back-to-back checks against signed products.
module tb_spm_seq;

   localparam int SIZE  = 32;
   localparam int P_DLY = 1;
   localparam int LAT   = 2*SIZE + P_DLY + 2;
   localparam int PER   = 2*SIZE + P_DLY + 3;

   logic        clk = 1'b0;
   logic        rst;
   logic        in_valid;
   logic        in_ready;
   logic [31:0] in_a, in_b;
   logic        out_valid;
   logic        out_ready;
   logic [63:0] out_prod;
   logic        mul_rst;
   logic [31:0] mul_x;
   logic        mul_y;
   logic        mul_p;

   int ncomp = 0;
   int nfail = 0;

   always #5 clk = ~clk;

   spm_seq #(.SIZE(SIZE), .P_DLY(P_DLY)) dut (
      .clk(clk), .rst(rst),
      .in_valid(in_valid), .in_ready(in_ready), .in_a(in_a), .in_b(in_b),
      .out_valid(out_valid), .out_ready(out_ready), .out_prod(out_prod),
      .mul_rst(mul_rst), .mul_x(mul_x), .mul_y(mul_y), .mul_p(mul_p)
   );

   // Multiplier model: product bit n is bit n of sext(x) * (y bits received so far),
   // returned one cycle after y bit n arrives.
   function automatic logic spm_bit(logic [31:0] x, logic [63:0] yacc, logic yb, int unsigned n);
      logic [63:0] xs, yy, pr;
      if (n >= 64) return 1'b0;
      xs = {{32{x[31]}}, x};
      yy = yacc | (64'(yb) << n);
      pr = xs * yy;
      return pr[n];
   endfunction

   int unsigned m_cnt;
   logic [63:0] m_y;
   always @(posedge clk) begin
      if (mul_rst) begin
         m_cnt <= 0;
         m_y   <= '0;
         mul_p <= 1'b0;
      end else begin
         m_y   <= (m_cnt < 64) ? (m_y | (64'(mul_y) << m_cnt)) : m_y;
         mul_p <= spm_bit(mul_x, m_y, mul_y, m_cnt);
         if (m_cnt < 127) m_cnt <= m_cnt + 1;
      end
   end

   function automatic logic [63:0] ref_prod(logic [31:0] a, logic [31:0] b);
      longint p;
      p = longint'($signed(a)) * longint'($signed(b));
      return 64'(p);
   endfunction

   task automatic check(string tag, logic [63:0] obs, logic [63:0] exp);
      ncomp++;
      assert (obs === exp) else begin
         nfail++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Accept one pair, wait for the result and check latency, value and handback.
   task automatic do_op(logic [31:0] a, logic [31:0] b);
      int k;
      logic [63:0] e;
      e = ref_prod(a, b);
      in_a = a; in_b = b; in_valid = 1'b1;
      check("in_ready_before_accept", 64'(in_ready), 64'd1);
      tick();
      in_valid = 1'b0;
      check("mul_rst_clr_cycle", 64'(mul_rst), 64'd1);
      k = 1;
      while (!out_valid && k < 200) begin
         tick();
         k++;
      end
      check("latency", 64'(k), 64'(LAT));
      check("out_prod", out_prod, e);
      check("mul_x_held", 64'(mul_x), 64'(a));
      $display("op a=%h b=%h prod=%h expected=%h cycles=%0d", a, b, out_prod, e, k);
      tick();
      check("out_valid_drop", 64'(out_valid), 64'd0);
      check("in_ready_after", 64'(in_ready), 64'd1);
   endtask

   initial begin
      logic [31:0] a, b;
      logic [63:0] e, held;
      logic [31:0] ra[4], rb[4];
      logic [63:0] expq[$];
      int idx, nres, last_cyc, cyc;
      logic acc;

      rst = 1'b1; in_valid = 1'b0; in_a = '0; in_b = '0; out_ready = 1'b1;
      repeat (3) tick();
      check("rst_out_valid", 64'(out_valid), 64'd0);
      check("rst_out_prod", out_prod, 64'd0);
      check("rst_mul_x", 64'(mul_x), 64'd0);
      check("rst_mul_y", 64'(mul_y), 64'd0);
      check("rst_in_ready", 64'(in_ready), 64'd0);
      check("rst_mul_rst", 64'(mul_rst), 64'd1);
      rst = 1'b0;
      #1;
      check("idle_in_ready", 64'(in_ready), 64'd1);
      check("idle_mul_rst", 64'(mul_rst), 64'd0);
      tick();

      // Directed values
      do_op(32'd3, 32'd5);
      check("spec_3x5", out_prod, 64'h0000_0000_0000_000F);
      do_op(32'hFFFF_FFFD, 32'd5);
      do_op(32'd7, 32'hFFFF_FFFF);
      do_op(32'h8000_0000, 32'h8000_0000);
      do_op(32'h7FFF_FFFF, 32'h7FFF_FFFF);
      do_op(32'h8000_0000, 32'h7FFF_FFFF);
      do_op(32'd0, 32'hDEAD_BEEF);

      // Random values
      for (int i = 0; i < 6; i++) do_op($urandom, $urandom);

      // Backpressure: result and operand must stay frozen
      a = $urandom; b = $urandom; e = ref_prod(a, b);
      out_ready = 1'b0;
      in_a = a; in_b = b; in_valid = 1'b1;
      tick();
      in_valid = 1'b0;
      cyc = 1;
      while (!out_valid && cyc < 200) begin tick(); cyc++; end
      check("bp_latency", 64'(cyc), 64'(LAT));
      held = out_prod;
      check("bp_prod", held, e);
      for (int i = 0; i < 20; i++) begin
         tick();
         check("bp_out_valid", 64'(out_valid), 64'd1);
         check("bp_out_prod", out_prod, e);
         check("bp_mul_x", 64'(mul_x), 64'(a));
         check("bp_in_ready", 64'(in_ready), 64'd0);
      end
      $display("op a=%h b=%h prod=%h expected=%h backpressure", a, b, out_prod, e);
      out_ready = 1'b1;
      tick();
      check("bp_release_valid", 64'(out_valid), 64'd0);
      check("bp_release_ready", 64'(in_ready), 64'd1);

      // Reset in the middle of SHIFT (counter 10 is cycle 12 after accept)
      in_a = $urandom; in_b = $urandom; in_valid = 1'b1;
      tick();
      in_valid = 1'b0;
      repeat (11) tick();
      rst = 1'b1;
      #1;
      check("midrst_mul_rst", 64'(mul_rst), 64'd1);
      check("midrst_in_ready", 64'(in_ready), 64'd0);
      tick();
      rst = 1'b0;
      #1;
      check("midrst_out_valid", 64'(out_valid), 64'd0);
      check("midrst_idle", 64'(in_ready), 64'd1);
      check("midrst_mul_rst_off", 64'(mul_rst), 64'd0);
      $display("op reset mid-shift");
      do_op(32'd2, 32'd3);
      check("midrst_2x3", out_prod, 64'd6);

      // Back-to-back with in_valid held high
      for (int i = 0; i < 4; i++) begin ra[i] = $urandom; rb[i] = $urandom; end
      idx = 0; nres = 0; last_cyc = -1; cyc = 0;
      while (nres < 4 && cyc < 600) begin
         if (out_valid) begin
            e = (expq.size() > 0) ? expq.pop_front() : 64'hx;
            check("b2b_prod", out_prod, e);
            if (last_cyc >= 0) check("b2b_spacing", 64'(cyc - last_cyc), 64'(PER));
            $display("op b2b result %0d prod=%h expected=%h cycle=%0d", nres, out_prod, e, cyc);
            last_cyc = cyc;
            nres++;
         end
         if (idx < 4) begin
            in_valid = 1'b1; in_a = ra[idx]; in_b = rb[idx];
         end else begin
            in_valid = 1'b0;
         end
         acc = in_ready && in_valid;
         if (acc) expq.push_back(ref_prod(ra[idx], rb[idx]));
         tick();
         cyc++;
         if (acc) idx++;
      end
      in_valid = 1'b0;
      check("b2b_count", 64'(nres), 64'd4);
      check("b2b_no_leftover", 64'(expq.size()), 64'd0);
      tick();
      check("b2b_no_dup", 64'(out_valid), 64'd0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncomp, nfail);
      $finish;
   end

endmodule
